// File: rtl/imem_loader.sv
// Packs a length-prefixed byte stream into 32-bit words and writes them to instruction memory from address 0.
// Latency: mem_we rises the cycle after the 4th byte of a word is accepted; done pulses one cycle after the last write.
// Backpressure: rx_ready drops in IDLE, WRITE and DONE; stream stalls of any length are tolerated.
`timescale 1ns/1ps
module imem_loader #(
    parameter int ADDR_W    = 9,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [15:0]       MAX_LEN = 16'(MEM_DEPTH);
    localparam logic [ADDR_W:0]   WL_ONE  = 1;
    localparam logic [ADDR_W-1:0] A_ONE   = 1;

    state_t      state, state_nxt;
    logic [15:0] len_q;
    logic [1:0]  byte_idx;
    logic [15:0] len_full;
    logic        len_ok;
    logic        last_word;

    assign len_full  = {rx_data, len_q[7:0]};
    assign len_ok    = (len_full != 16'd0) && (len_full <= MAX_LEN);
    assign last_word = (16'(words_loaded) + 16'd1) == len_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rx_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_LEN_LO;
            end
            S_LEN_LO: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = S_LEN_HI;
            end
            S_LEN_HI: begin
                rx_ready = 1'b1;
                if (rx_valid) state_nxt = len_ok ? S_DATA : S_IDLE;
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (rx_valid && byte_idx == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                state_nxt = last_word ? S_DONE : S_DATA;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The address is held after the final write so it can never wrap past the top of memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q        <= '0;
            byte_idx     <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        error        <= 1'b0;
                        words_loaded <= '0;
                        byte_idx     <= '0;
                        mem_addr     <= '0;
                    end
                end
                S_LEN_LO: begin
                    if (rx_valid) len_q[7:0] <= rx_data;
                end
                S_LEN_HI: begin
                    if (rx_valid) begin
                        len_q[15:8] <= rx_data;
                        if (!len_ok) error <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        mem_wdata[{byte_idx, 3'b000} +: 8] <= rx_data;
                        byte_idx <= byte_idx + 2'd1;
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_loaded + WL_ONE;
                    if (!last_word) mem_addr <= mem_addr + A_ONE;
                end
                default: ;
            endcase
        end
    end

endmodule
